// File: rtl/store_buffer_pkg.sv
// Shared configuration, LSU op encoding, buffer entry type and byte-lane
// helpers used by the store buffer (lsu_op_size is also used by the dcache).
package config_pkg;

    typedef struct packed {
        int unsigned PLEN;
        int unsigned XLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{PLEN: 32'd32, XLEN: 32'd64};

endpackage

package store_buffer_pkg;

    import config_pkg::*;

    localparam int unsigned PLEN   = EmptyCfg.PLEN;
    localparam int unsigned XLEN   = EmptyCfg.XLEN;
    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        LB      = 4'd1,
        LBU     = 4'd2,
        LH      = 4'd3,
        LHU     = 4'd4,
        LW      = 4'd5,
        LWU     = 4'd6,
        LD      = 4'd7,
        SB      = 4'd8,
        SH      = 4'd9,
        SW      = 4'd10,
        SD      = 4'd11
    } lsu_op_e;

    typedef struct packed {
        logic [PLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        lsu_op_e           op;
        logic [NBYTES-1:0] mask;
    } sb_entry_t;

    // Access size in bytes; unknown ops report zero so they cover no lanes.
    function automatic logic [3:0] lsu_op_size(input lsu_op_e op);
        case (op)
            LB, LBU, SB: return 4'd1;
            LH, LHU, SH: return 4'd2;
            LW, LWU, SW: return 4'd4;
            LD, SD:      return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

    // Byte lanes touched by an access of 'size' bytes starting at lane 'offset'.
    function automatic logic [NBYTES-1:0] byte_mask(input logic [3:0] size,
                                                    input logic [OFF_W-1:0] offset);
        logic [15:0] ones;
        ones = (16'd1 << size) - 16'd1;
        return NBYTES'(ones) << offset;
    endfunction

    // Expand a byte-lane mask into a bit mask over the data word.
    function automatic logic [XLEN-1:0] mask_to_bits(input logic [NBYTES-1:0] m);
        logic [XLEN-1:0] b;
        for (int i = 0; i < NBYTES; i++) begin
            b[i*8 +: 8] = {8{m[i]}};
        end
        return b;
    endfunction

    function automatic logic is_store(input lsu_op_e op);
        case (op)
            SB, SH, SW, SD: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [3:0] size, input logic [OFF_W-1:0] offset);
        return (offset & OFF_W'(size - 4'd1)) == {OFF_W{1'b0}};
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the commit push port, dcache store request port, load forwarding
// port and status outputs of the store buffer.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             push_valid_i;
    logic             push_ready_o;
    logic [PLEN-1:0]  push_addr_i;
    logic [XLEN-1:0]  push_data_i;
    lsu_op_e          push_op_i;

    logic             st_req_valid_o;
    logic             st_req_ready_i;
    logic [PLEN-1:0]  st_req_addr_o;
    logic [XLEN-1:0]  st_req_data_o;
    lsu_op_e          st_req_op_o;

    logic [PLEN-1:0]  fwd_addr_i;
    lsu_op_e          fwd_op_i;
    logic             fwd_hit_o;
    logic             fwd_conflict_o;
    logic [XLEN-1:0]  fwd_data_o;

    logic             empty_o;
    logic [CNT_W-1:0] count_o;

    modport slave (
        input  push_valid_i, push_addr_i, push_data_i, push_op_i,
        output push_ready_o,
        output st_req_valid_o, st_req_addr_o, st_req_data_o, st_req_op_o,
        input  st_req_ready_i,
        input  fwd_addr_i, fwd_op_i,
        output fwd_hit_o, fwd_conflict_o, fwd_data_o,
        output empty_o, count_o
    );

    modport master (
        output push_valid_i, push_addr_i, push_data_i, push_op_i,
        input  push_ready_o,
        input  st_req_valid_o, st_req_addr_o, st_req_data_o, st_req_op_o,
        output st_req_ready_i,
        output fwd_addr_i, fwd_op_i,
        input  fwd_hit_o, fwd_conflict_o, fwd_data_o,
        input  empty_o, count_o
    );

endinterface

// File: rtl/store_buffer_fwd.sv
// Combinational store-to-load forwarding: merges buffered store bytes
// oldest-to-youngest so the youngest covering store wins each load byte.
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t         entries_i [DEPTH],
    input  logic [PTR_W-1:0]  head_i,
    input  logic [PTR_W:0]    count_i,
    input  logic [PLEN-1:0]   addr_i,
    input  lsu_op_e           op_i,
    output logic              hit_o,
    output logic              conflict_o,
    output logic [XLEN-1:0]   data_o
);

    logic [NBYTES-1:0] cov_s;
    logic [XLEN-1:0]   merged_s;
    logic [NBYTES-1:0] load_mask_s;
    logic [NBYTES-1:0] covered_s;

    // Walk valid entries from the head (oldest) so younger stores overwrite older bytes.
    always_comb begin : merge_p
        sb_entry_t         ent;
        logic [PTR_W-1:0]  idx;
        logic [NBYTES-1:0] sel;
        logic [XLEN-1:0]   sel_bits;
        logic [XLEN-1:0]   lane;
        cov_s    = {NBYTES{1'b0}};
        merged_s = {XLEN{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            idx      = head_i + PTR_W'(k);
            ent      = entries_i[idx];
            sel      = (((PTR_W+1)'(k) < count_i) &&
                        (ent.addr[PLEN-1:OFF_W] == addr_i[PLEN-1:OFF_W])) ? ent.mask
                                                                          : {NBYTES{1'b0}};
            sel_bits = mask_to_bits(sel);
            lane     = ent.data << {ent.addr[OFF_W-1:0], 3'b000};
            merged_s = (merged_s & ~sel_bits) | (lane & sel_bits);
            cov_s    = cov_s | sel;
        end
    end

    // Classify coverage of the load bytes and align the merged data to the LSB.
    always_comb begin
        load_mask_s = byte_mask(lsu_op_size(op_i), addr_i[OFF_W-1:0]);
        covered_s   = cov_s & load_mask_s;
        hit_o       = (load_mask_s != {NBYTES{1'b0}}) && (covered_s == load_mask_s);
        conflict_o  = (covered_s != {NBYTES{1'b0}}) && !hit_o;
        data_o      = hit_o ? ((merged_s & mask_to_bits(load_mask_s)) >> {addr_i[OFF_W-1:0], 3'b000})
                            : {XLEN{1'b0}};
    end

endmodule

// File: rtl/store_buffer.sv
// In-order buffer of committed stores draining oldest-first toward the dcache,
// with byte-granular forwarding to younger loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg   = config_pkg::EmptyCfg,
    parameter int unsigned      DEPTH = 8
) (
    input logic           clk_i,
    input logic           rst_ni,
    store_buffer_if.slave sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push_fire_s;
    logic                 pop_fire_s;
    logic                 empty_s;
    sb_entry_t            push_entry_s;
    sb_entry_t            head_entry_s;
    logic [Cfg.PLEN-1:0]  fwd_addr_s;
    logic [Cfg.XLEN-1:0]  fwd_data_s;

    // Acceptance depends only on registered occupancy: a full buffer stays full this cycle.
    assign empty_s         = (count_q == {CNT_W{1'b0}});
    assign sb.push_ready_o = (count_q < CNT_W'(DEPTH));
    assign push_fire_s     = sb.push_valid_i && sb.push_ready_o;
    assign pop_fire_s      = !empty_s && sb.st_req_ready_i;

    assign head_entry_s      = mem_q[head_q];
    assign sb.st_req_valid_o = !empty_s;
    assign sb.st_req_addr_o  = head_entry_s.addr;
    assign sb.st_req_data_o  = head_entry_s.data;
    assign sb.st_req_op_o    = head_entry_s.op;
    assign sb.empty_o        = empty_s;
    assign sb.count_o        = count_q;

    assign fwd_addr_s    = sb.fwd_addr_i;
    assign sb.fwd_data_o = fwd_data_s;

    // Build the entry for an incoming store, including its byte-lane mask.
    always_comb begin
        push_entry_s.addr = sb.push_addr_i;
        push_entry_s.data = sb.push_data_i;
        push_entry_s.op   = sb.push_op_i;
        push_entry_s.mask = byte_mask(lsu_op_size(sb.push_op_i), sb.push_addr_i[OFF_W-1:0]);
    end

    // Next-state for the circular pointers and the occupancy count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop_fire_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        if (push_fire_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        count_d = count_q + CNT_W'(push_fire_s) - CNT_W'(pop_fire_s);
    end

    // Pointer and count registers; reset discards all buffered stores.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_fire_s) begin
            mem_q[tail_q] <= push_entry_s;
        end
    end

    store_buffer_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries_i  (mem_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .addr_i     (fwd_addr_s),
        .op_i       (sb.fwd_op_i),
        .hit_o      (sb.fwd_hit_o),
        .conflict_o (sb.fwd_conflict_o),
        .data_o     (fwd_data_s)
    );

    store_buffer_chk u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_fire_i (push_fire_s),
        .op_i        (sb.push_op_i),
        .offset_i    (sb.push_addr_i[OFF_W-1:0])
    );

endmodule

// Simulation checks on accepted pushes: only naturally aligned store ops are legal.
module store_buffer_chk
    import store_buffer_pkg::*;
(
    input logic             clk_i,
    input logic             rst_ni,
    input logic             push_fire_i,
    input lsu_op_e          op_i,
    input logic [OFF_W-1:0] offset_i
);

    // Flag illegal store traffic at the cycle it is accepted.
    always @(posedge clk_i) begin
        if (rst_ni && push_fire_i) begin
            assert (is_store(op_i)) else $error("store_buffer: push of non-store op %0d", op_i);
            assert (is_aligned(lsu_op_size(op_i), offset_i))
                else $error("store_buffer: misaligned push, op %0d offset %0d", op_i, offset_i);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed sequences, a forwarding vector table and
// random traffic checked against a queue-based reference model.
module tb_store_buffer;

    import store_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    store_buffer_if #(.DEPTH(DEPTH)) sb_if ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sb     (sb_if)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        lsu_op_e     op;
    } st_t;

    typedef struct {
        lsu_op_e     op;
        logic [31:0] addr;
        logic        hit;
        logic        conf;
        logic [63:0] data;
    } fwd_vec_t;

    st_t      q[$];
    fwd_vec_t vecs[10];
    int       n_total = 0;
    int       n_pass  = 0;
    int       popped_n = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    function automatic int op_bytes(input lsu_op_e op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, LWU, SW: return 4;
            default:     return 8;
        endcase
    endfunction

    // Reference forwarding: per load byte, search stores youngest-first by byte address range.
    task automatic fwd_model(input logic [31:0] addr, input lsu_op_e op,
                             output logic hit, output logic conf, output logic [63:0] data);
        int n = op_bytes(op);
        int covered = 0;
        data = 64'd0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a = addr + 32'(i);
            for (int j = q.size() - 1; j >= 0; j--) begin
                if (a >= q[j].addr && a < q[j].addr + 32'(op_bytes(q[j].op))) begin
                    logic [63:0] b = q[j].data >> (8 * (a - q[j].addr));
                    data[i*8 +: 8] = b[7:0];
                    covered++;
                    break;
                end
            end
        end
        hit  = (covered == n);
        conf = (covered > 0) && (covered < n);
        if (!hit) data = 64'd0;
    endtask

    // Per-cycle scoreboard: compare outputs with the model, then apply this edge's push/pop.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q.delete();
        end else begin
            logic mh, mc;
            logic [63:0] md;
            bit do_pop, do_push;
            chk("push_ready", sb_if.push_ready_o, q.size() < DEPTH);
            chk("st_valid", sb_if.st_req_valid_o, q.size() != 0);
            chk("count", sb_if.count_o, q.size());
            chk("empty", sb_if.empty_o, q.size() == 0);
            if (q.size() != 0) begin
                chk("st_addr", sb_if.st_req_addr_o, q[0].addr);
                chk("st_data", sb_if.st_req_data_o, q[0].data);
                chk("st_op", sb_if.st_req_op_o, q[0].op);
            end
            fwd_model(sb_if.fwd_addr_i, sb_if.fwd_op_i, mh, mc, md);
            chk("fwd_hit", sb_if.fwd_hit_o, mh);
            chk("fwd_conflict", sb_if.fwd_conflict_o, mc);
            if (mh) chk("fwd_data", sb_if.fwd_data_o, md);
            do_push = sb_if.push_valid_i && (q.size() < DEPTH);
            do_pop  = sb_if.st_req_ready_i && (q.size() != 0);
            if (do_pop) begin
                void'(q.pop_front());
                popped_n++;
            end
            if (do_push) q.push_back('{sb_if.push_addr_i, sb_if.push_data_i, sb_if.push_op_i});
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        sb_if.push_valid_i   = 1'b0;
        sb_if.st_req_ready_i = 1'b0;
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
    endtask

    task automatic push(input lsu_op_e op, input logic [31:0] addr, input logic [63:0] data);
        sb_if.push_valid_i = 1'b1;
        sb_if.push_op_i    = op;
        sb_if.push_addr_i  = addr;
        sb_if.push_data_i  = data;
        cyc();
        sb_if.push_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        sb_if.st_req_ready_i = 1'b1;
        for (int i = 0; i < 20 && sb_if.empty_o !== 1'b1; i++) cyc();
        sb_if.st_req_ready_i = 1'b0;
        chk(name, sb_if.empty_o, 1'b1);
    endtask

    function automatic lsu_op_e rand_store();
        case ($urandom_range(0, 3))
            0:       return SB;
            1:       return SH;
            2:       return SW;
            default: return SD;
        endcase
    endfunction

    function automatic lsu_op_e rand_load();
        case ($urandom_range(0, 6))
            0:       return LB;
            1:       return LBU;
            2:       return LH;
            3:       return LHU;
            4:       return LW;
            5:       return LWU;
            default: return LD;
        endcase
    endfunction

    initial begin
        vecs[0] = '{LW,  32'h1000, 1'b1, 1'b0, 64'h00000000AABBEEDD};
        vecs[1] = '{LW,  32'h2000, 1'b0, 1'b1, 64'h0};
        vecs[2] = '{LB,  32'h2003, 1'b1, 1'b0, 64'h5A};
        vecs[3] = '{LB,  32'h2004, 1'b0, 1'b0, 64'h0};
        vecs[4] = '{LB,  32'h1001, 1'b1, 1'b0, 64'hEE};
        vecs[5] = '{LH,  32'h1002, 1'b1, 1'b0, 64'hAABB};
        vecs[6] = '{LD,  32'h1000, 1'b0, 1'b1, 64'h0};
        vecs[7] = '{LB,  32'h1005, 1'b0, 1'b0, 64'h0};
        vecs[8] = '{LBU, 32'h1003, 1'b1, 1'b0, 64'hAA};
        vecs[9] = '{LW,  32'h1004, 1'b0, 1'b0, 64'h0};

        sb_if.push_valid_i   = 1'b0;
        sb_if.push_op_i      = SD;
        sb_if.push_addr_i    = 32'd0;
        sb_if.push_data_i    = 64'd0;
        sb_if.st_req_ready_i = 1'b0;
        sb_if.fwd_addr_i     = 32'h8000_0000;
        sb_if.fwd_op_i       = LD;

        // Reset state and single store latency
        do_reset();
        chk("rst_push_ready", sb_if.push_ready_o, 1'b1);
        chk("rst_st_valid", sb_if.st_req_valid_o, 1'b0);
        chk("rst_empty", sb_if.empty_o, 1'b1);
        chk("rst_count", sb_if.count_o, 0);
        chk("rst_fwd_hit", sb_if.fwd_hit_o, 1'b0);
        chk("rst_fwd_conflict", sb_if.fwd_conflict_o, 1'b0);
        chk("rst_fwd_data", sb_if.fwd_data_o, 64'd0);
        push(SD, 32'h8000_0000, 64'h1122334455667788);
        chk("t1_valid", sb_if.st_req_valid_o, 1'b1);
        chk("t1_addr", sb_if.st_req_addr_o, 32'h8000_0000);
        chk("t1_data", sb_if.st_req_data_o, 64'h1122334455667788);
        chk("t1_op", sb_if.st_req_op_o, SD);
        sb_if.st_req_ready_i = 1'b1;
        cyc();
        sb_if.st_req_ready_i = 1'b0;
        chk("t1_empty_after", sb_if.empty_o, 1'b1);

        // Full buffer: rejects even with a concurrent pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            sb_if.push_valid_i = 1'b1;
            sb_if.push_op_i    = SD;
            sb_if.push_addr_i  = 32'h100 + 32'(8 * i);
            sb_if.push_data_i  = 64'hC0DE_0000_0000_0000 + 64'(i);
            cyc();
        end
        sb_if.push_addr_i = 32'h200;
        sb_if.push_data_i = 64'hDEAD_BEEF_0000_0009;
        chk("t2_count_full", sb_if.count_o, DEPTH);
        chk("t2_ready_full", sb_if.push_ready_o, 1'b0);
        cyc();
        chk("t2_held", sb_if.count_o, DEPTH);
        sb_if.st_req_ready_i = 1'b1;
        cyc();
        sb_if.st_req_ready_i = 1'b0;
        chk("t2_pop_no_push", sb_if.count_o, DEPTH - 1);
        cyc();
        sb_if.push_valid_i = 1'b0;
        chk("t2_push_next", sb_if.count_o, DEPTH);
        drain("t2_drained");

        // Forwarding table
        do_reset();
        push(SW, 32'h1000, 64'hAABBCCDD);
        push(SB, 32'h1001, 64'hEE);
        push(SB, 32'h2003, 64'h5A);
        foreach (vecs[i]) begin
            sb_if.fwd_op_i   = vecs[i].op;
            sb_if.fwd_addr_i = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d_hit", i), sb_if.fwd_hit_o, vecs[i].hit);
            chk($sformatf("vec%0d_conflict", i), sb_if.fwd_conflict_o, vecs[i].conf);
            if (!vecs[i].conf) chk($sformatf("vec%0d_data", i), sb_if.fwd_data_o, vecs[i].data);
        end
        drain("t3_drained");

        // Pointer wrap: 8 pushes, 3 pops, 3 pushes, full drain
        do_reset();
        popped_n = 0;
        for (int i = 0; i < DEPTH; i++) push(SD, 32'h4000 + 32'(8 * i), {$urandom, $urandom});
        sb_if.st_req_ready_i = 1'b1;
        repeat (3) cyc();
        sb_if.st_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push(SW, 32'h5000 + 32'(4 * i), {$urandom, $urandom});
        chk("t4_count", sb_if.count_o, DEPTH);
        drain("t4_drained");
        chk("t4_popped", popped_n, 11);

        // Reset mid-drain
        do_reset();
        for (int i = 0; i < 5; i++) push(SH, 32'h6000 + 32'(2 * i), 64'(i));
        chk("t5_count", sb_if.count_o, 5);
        chk("t5_valid", sb_if.st_req_valid_o, 1'b1);
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        chk("t5_empty", sb_if.empty_o, 1'b1);
        chk("t5_valid_rst", sb_if.st_req_valid_o, 1'b0);
        chk("t5_count_rst", sb_if.count_o, 0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            lsu_op_e so = rand_store();
            lsu_op_e lo = rand_load();
            int      ss = op_bytes(so);
            int      ls = op_bytes(lo);
            sb_if.push_valid_i   = ($urandom_range(0, 9) < 7);
            sb_if.push_op_i      = so;
            sb_if.push_addr_i    = 32'h3000 + 32'(8 * $urandom_range(0, 3))
                                 + 32'(ss * $urandom_range(0, 8 / ss - 1));
            sb_if.push_data_i    = {$urandom, $urandom};
            sb_if.st_req_ready_i = ($urandom_range(0, 1) == 1);
            sb_if.fwd_op_i       = lo;
            sb_if.fwd_addr_i     = 32'h3000 + 32'(8 * $urandom_range(0, 3))
                                 + 32'(ls * $urandom_range(0, 8 / ls - 1));
            cyc();
        end
        sb_if.push_valid_i = 1'b0;
        drain("rand_drained");
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order buffer of committed (retired) stores, sitting directly upstream of the dcache AXI wrapper's store port.
- Accepts one committed store per cycle from the commit stage.
- Drains entries oldest-first into the dcache store request handshake.
- Provides same-cycle byte-granular store-to-load forwarding to the LSU load path, so younger loads observe not-yet-drained stores.

Parameters:
- Cfg, config_pkg::EmptyCfg, global config; uses Cfg.PLEN and Cfg.XLEN.
- DEPTH, 8, number of entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- push_valid_i  in  1  committed store valid.
- push_ready_o  out  1  buffer can accept a store.
- push_addr_i  in  PLEN  store byte address; naturally aligned.
- push_data_i  in  XLEN  store data, right-justified (byte 0 = LSB).
- push_op_i  in  lsu_op_e  store op (SB/SH/SW/SD).
- st_req_valid_o  out  1  head entry valid toward dcache.
- st_req_ready_i  in  1  dcache accepts the store.
- st_req_addr_o  out  PLEN  head address.
- st_req_data_o  out  XLEN  head data, unmodified.
- st_req_op_o  out  lsu_op_e  head op.
- fwd_addr_i  in  PLEN  load address to check.
- fwd_op_i  in  lsu_op_e  load op; size is used only.
- fwd_hit_o  out  1  every load byte is covered by buffered stores.
- fwd_conflict_o  out  1  some but not all load bytes are covered; load must retry.
- fwd_data_o  out  XLEN  merged bytes, shifted so the load's byte 0 is at the LSB; upper bytes zero; no sign extension.
- empty_o  out  1  no entries (used by fence/drain).
- count_o  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage:
  - Circular array with head/tail pointers ($clog2(DEPTH) bits, wrap at DEPTH) plus a count register.
  - Entry fields: addr, data, op, byte mask.
  - Byte mask is computed at push from size and addr[$clog2(XLEN/8)-1:0].
- Reset (rst_ni low at posedge):
  - head = tail = count = 0.
  - Outputs: push_ready_o=1, st_req_valid_o=0, empty_o=1, count_o=0, fwd_hit_o=0, fwd_conflict_o=0, fwd_data_o=0.
  - Entry payloads are don't-care.
  - Reset mid-drain discards all contents.
- Push:
  - push_ready_o = (count < DEPTH), taken from registered count only; no same-cycle pop bypass, so a full buffer rejects even when a pop occurs.
  - On push_valid_i && push_ready_o, the entry is written at tail and tail++.
  - The entry becomes visible to drain and forwarding the next cycle.
- Drain:
  - st_req_valid_o = !empty; outputs driven directly from the head entry.
  - Valid/payload stay stable until st_req_ready_i; pop (head++) on valid&&ready.
  - Minimum latency push -> st_req_valid_o is 1 cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Count update: count_d = count + push_fire - pop_fire.
- Forwarding (combinational, all valid entries including one being popped this cycle):
  - Candidate entries: addr[PLEN-1:$clog2(XLEN/8)] equals the load's.
  - For each load byte, take data from the youngest candidate whose mask covers it (age measured from head).
  - hit = all load bytes covered.
  - conflict = at least one but not all covered.
  - If no bytes are covered, hit=0, conflict=0, fwd_data_o=0.
  - fwd_data_o is valid only when hit=1.
- flush_i does not exist: committed stores are never squashed.
- Error checks:
  - Misaligned push is a simulation $error.
  - Push of a non-store op is a simulation $error.

Decomposition:
- Shared package, store_buffer_pkg:
  - sb_entry_t (addr, data, op, mask).
  - Function lsu_op_size(lsu_op_e) returning 1/2/4/8 bytes.
  - Function byte_mask(size, offset).
  - lsu_op_size is reused by dcache.
- Sub-module: store_buffer_fwd, purely combinational age-ordered byte merge. Takes entry array, head, count, and load addr/op; returns hit, conflict, data.

Test Plan:
- Reset, then SD 0x8000_0000 = 0x1122334455667788 -> next cycle st_req_valid_o=1, addr 0x8000_0000, data unchanged; ready=1 -> empty_o=1 the following cycle.
- Push 8 stores with st_req_ready_i=0 -> count_o=8, push_ready_o=0; 9th push held. Assert ready with a push in the same cycle -> push still rejected that cycle, accepted the next cycle.
- SW 0x1000 = 0xAABBCCDD, then SB 0x1001 = 0xEE; LW 0x1000 -> fwd_hit_o=1, fwd_data_o=0x00000000AABBEEDD (younger byte wins).
- SB 0x2003 = 0x5A; LW 0x2000 -> fwd_conflict_o=1, fwd_hit_o=0. LB 0x2003 -> hit, data 0x5A. LB 0x2004 -> hit=0, conflict=0.
- Fill to DEPTH, drain 3, push 3 more (pointer wrap) -> dcache receives all 11 stores in push order with exact payloads.
- Reset asserted while count=5 and st_req_valid_o=1 -> next cycle empty_o=1, st_req_valid_o=0, count_o=0.
